// File: rtl/fp_add_pkg.sv
// Shared FP-adder definitions: exponent-path defaults, the comparator result
// record and the magnitude/saturation helper used by the alignment stage.
package fp_add_pkg;

    localparam int EXP_W_DEF     = 8;
    localparam int SHIFT_MAX_DEF = 27;
    localparam int SHIFT_W_DEF   = $clog2(SHIFT_MAX_DEF + 1);
    // Widest exponent the helper handles; callers sign-extend their difference to this.
    localparam int EXP_W_MAX     = 16;

    typedef struct packed {
        logic                   diff_sign;
        logic [SHIFT_W_DEF-1:0] shift_amt;
        logic                   shift_sat;
        logic [EXP_W_DEF-1:0]   exp_max;
        logic                   exp_eq;
    } comp_res_t;

    typedef struct packed {
        logic                 sat;
        logic [EXP_W_MAX-1:0] amt;
    } abs_sat_t;

    function automatic abs_sat_t exp_abs_sat(input logic [EXP_W_MAX:0] diff,
                                             input int                 shift_max);
        logic [EXP_W_MAX-1:0] mag;
        abs_sat_t             res;
        if (diff[EXP_W_MAX]) begin
            mag = ~diff[EXP_W_MAX-1:0] + EXP_W_MAX'(1'b1);
        end else begin
            mag = diff[EXP_W_MAX-1:0];
        end
        res.sat = (mag > EXP_W_MAX'(shift_max));
        if (res.sat) begin
            res.amt = EXP_W_MAX'(shift_max);
        end else begin
            res.amt = mag;
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_stage_rv.sv
// Single valid/ready register slice; a bubble is refilled even while the
// consumer stalls, so a chain of N slices holds N transactions.
module pipe_stage_rv #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_r;
    logic [W-1:0] data_r;

    assign in_ready  = ~valid_r | out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slice register: load on advance, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {W{1'b0}};
        end else if (in_ready) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/comp_exp_pipe.sv
// Two-stage pipelined exponent comparator for the FP adder alignment path.
// Optional macro COMP_EXP_SPECIAL_EN adds all-ones (Inf/NaN) exponent flags.
module comp_exp_pipe
    import fp_add_pkg::*;
#(
    parameter  int EXP_W     = EXP_W_DEF,
    parameter  int SHIFT_MAX = SHIFT_MAX_DEF,
    localparam int SHIFT_W   = $clog2(SHIFT_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*EXP_W-1:0] exponenti,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               diff_sign,
    output logic [SHIFT_W-1:0] shift_amt,
    output logic               shift_sat,
    output logic [EXP_W-1:0]   exp_max,
    output logic               exp_eq
`ifdef COMP_EXP_SPECIAL_EN
    ,
    output logic               special_a,
    output logic               special_b
`endif
);

`ifdef COMP_EXP_SPECIAL_EN
    localparam int SPEC_W = 2;
`else
    localparam int SPEC_W = 0;
`endif
    localparam int P1_W = (EXP_W + 1) + 2 * EXP_W + SPEC_W;
    localparam int P2_W = 3 + SHIFT_W + EXP_W + SPEC_W;

    logic [EXP_W-1:0]     exp_a_s;
    logic [EXP_W-1:0]     exp_b_s;
    logic [EXP_W:0]       diff_s;
    logic [P1_W-1:0]      s1_in_s;
    logic [P1_W-1:0]      s1_data_s;
    logic                 s1_valid_s;
    logic                 s2_ready_s;
    logic [EXP_W:0]       s1_diff_s;
    logic [EXP_W-1:0]     s1_exp_a_s;
    logic [EXP_W-1:0]     s1_exp_b_s;
    logic [EXP_W_MAX:0]   diff_ext_s;
    abs_sat_t             abs_s;
    logic                 res_sign_s;
    logic [SHIFT_W-1:0]   res_amt_s;
    logic [EXP_W-1:0]     res_max_s;
    logic                 res_eq_s;
    logic [P2_W-1:0]      s2_in_s;
    logic [P2_W-1:0]      s2_data_s;
`ifdef COMP_EXP_SPECIAL_EN
    logic                 spec_a_s;
    logic                 spec_b_s;
    logic                 s1_spec_a_s;
    logic                 s1_spec_b_s;
`endif

    // Stage 1: unsigned difference with an extra bit carrying the sign.
    assign exp_a_s = exponenti[EXP_W-1:0];
    assign exp_b_s = exponenti[2*EXP_W-1:EXP_W];
    assign diff_s  = {1'b0, exp_a_s} - {1'b0, exp_b_s};
`ifdef COMP_EXP_SPECIAL_EN
    assign spec_a_s = &exp_a_s;
    assign spec_b_s = &exp_b_s;
    assign s1_in_s  = {diff_s, exp_a_s, exp_b_s, spec_a_s, spec_b_s};
`else
    assign s1_in_s  = {diff_s, exp_a_s, exp_b_s};
`endif

    pipe_stage_rv #(.W(P1_W)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in_s),
        .out_valid (s1_valid_s),
        .out_ready (s2_ready_s),
        .out_data  (s1_data_s)
    );

`ifdef COMP_EXP_SPECIAL_EN
    assign {s1_diff_s, s1_exp_a_s, s1_exp_b_s, s1_spec_a_s, s1_spec_b_s} = s1_data_s;
`else
    assign {s1_diff_s, s1_exp_a_s, s1_exp_b_s} = s1_data_s;
`endif

    // Stage 2: sign-extend so the shared helper sees the true signed difference.
    assign diff_ext_s = (EXP_W_MAX + 1)'($signed(s1_diff_s));
    assign abs_s      = exp_abs_sat(diff_ext_s, SHIFT_MAX);
    assign res_sign_s = s1_diff_s[EXP_W];
    assign res_amt_s  = SHIFT_W'(abs_s.amt);
    assign res_max_s  = res_sign_s ? s1_exp_b_s : s1_exp_a_s;
    assign res_eq_s   = (s1_diff_s == {(EXP_W + 1){1'b0}});
`ifdef COMP_EXP_SPECIAL_EN
    assign s2_in_s = {res_sign_s, res_amt_s, abs_s.sat, res_max_s, res_eq_s,
                      s1_spec_a_s, s1_spec_b_s};
`else
    assign s2_in_s = {res_sign_s, res_amt_s, abs_s.sat, res_max_s, res_eq_s};
`endif

    pipe_stage_rv #(.W(P2_W)) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_ready_s),
        .in_data   (s2_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data_s)
    );

`ifdef COMP_EXP_SPECIAL_EN
    assign {diff_sign, shift_amt, shift_sat, exp_max, exp_eq, special_a, special_b} = s2_data_s;
`else
    assign {diff_sign, shift_amt, shift_sat, exp_max, exp_eq} = s2_data_s;
`endif

endmodule

// File: doc/comp_exp_pipe.md
Name: comp_exp_pipe

Overview:
- Parametrised, pipelined successor to the combinational exponent comparator in the FP adder datapath.
- Takes two packed biased exponents and returns:
  - the signed-difference direction;
  - the alignment shift amount, saturated to the mantissa shift range;
  - the larger exponent;
  - an equality flag.
- Two register stages with valid/ready handshake. Sits between operand unpack and the mantissa alignment shifter.

Parameters:
- EXP_W, 8, exponent width in bits (>=2).
- SHIFT_MAX, 27, largest meaningful alignment shift (mantissa + guard/round/sticky). Larger differences saturate to this value.
- SHIFT_W, $clog2(SHIFT_MAX+1), localparam; width of shift_amt.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- exponenti  in  2*EXP_W  packed exponents: exp_a = [EXP_W-1:0], exp_b = [2*EXP_W-1:EXP_W].
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- diff_sign  out  1  1 when exp_a < exp_b (exp_a - exp_b negative).
- shift_amt  out  SHIFT_W  min(|exp_a - exp_b|, SHIFT_MAX).
- shift_sat  out  1  |exp_a - exp_b| > SHIFT_MAX.
- exp_max  out  EXP_W  larger of exp_a, exp_b.
- exp_eq  out  1  exp_a == exp_b.
- special_a, special_b  out  1 each  only with COMP_EXP_SPECIAL_EN (see below).

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - s1_valid = 0 and s2_valid = 0.
  - All output data registers = 0: out_valid, diff_sign, shift_amt, shift_sat, exp_max, exp_eq.
  - in_ready may be 1 in the cycle after reset.
- Reset mid-operation: in-flight transactions are discarded, not completed. An input presented in the reset cycle is not accepted.
- Stage 1 (on accept):
  - Register diff = {1'b0,exp_a} - {1'b0,exp_b}, EXP_W+1 bits; bit EXP_W is the sign.
  - Register exp_a and exp_b.
- Stage 2:
  - mag = sign ? (~diff[EXP_W-1:0] + 1) : diff[EXP_W-1:0]. Arithmetic is EXP_W bits. For EXP_W=8, |diff| <= 255 and never overflows.
  - shift_sat = (mag > SHIFT_MAX); shift_amt = shift_sat ? SHIFT_MAX : mag[SHIFT_W-1:0].
  - exp_max = sign ? exp_b : exp_a.
  - exp_eq = (diff == 0); diff_sign = sign.
- Latency:
  - Exactly 2 cycles from an accepting edge (in_valid & in_ready) to out_valid, when out_ready is held high.
  - Throughput is 1 per cycle.
- Handshake:
  - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1.
  - in_ready depends combinationally on out_ready only. There is no combinational path from in_* to out_*.
  - When out_valid & !out_ready, output data and out_valid hold stable.
  - A bubble in stage 2 is filled even while out_ready=0.
  - Capacity is 2 transactions; order is preserved, with no drop or duplication.
  - Simultaneous accept and emit in the same cycle is legal and keeps full throughput.
- Saturation boundary:
  - |diff| == SHIFT_MAX gives shift_amt = SHIFT_MAX, shift_sat = 0.
  - SHIFT_MAX + 1 gives shift_sat = 1.
- Equal exponents: diff_sign = 0, shift_amt = 0, exp_eq = 1, exp_max = exp_a.

Optional Feature:
- Macro: COMP_EXP_SPECIAL_EN.
- Defined:
  - Adds ports special_a and special_b, set when the respective exponent is all-ones (Inf/NaN), or all-zeros if the operand is subnormal/zero… all-ones only; zero exponents are not flagged.
  - The flags are pipelined alongside the data, with the same latency and handshake, and reset to 0.
- Undefined: the ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package fp_add_pkg:
  - EXP_W default.
  - SHIFT_MAX default.
  - Packed result struct type {diff_sign, shift_amt, shift_sat, exp_max, exp_eq}.
  - Function exp_abs_sat(diff) implementing the stage-2 arithmetic.
- One natural sub-module, pipe_stage_rv: a single valid/ready register slice parametrised by payload width.
  - Instantiate it twice.
  - Keep the arithmetic in the top module.

Test Plan (EXP_W=8, SHIFT_MAX=27, out_ready=1 unless stated):
1. exp_a=0x85, exp_b=0x80 -> 2 cycles later: out_valid=1, diff_sign=0, shift_amt=5, shift_sat=0, exp_max=0x85, exp_eq=0.
2. exp_a=0x10, exp_b=0x90 (diff -128) -> diff_sign=1, shift_amt=27, shift_sat=1, exp_max=0x90. Also check the boundary cases:
   - exp_a=0x9B, exp_b=0x80 gives shift_amt=27, shift_sat=0.
   - exp_a=0x9C, exp_b=0x80 gives shift_sat=1.
3. exp_a=exp_b=0x7F -> exp_eq=1, diff_sign=0, shift_amt=0, exp_max=0x7F.
4. Backpressure:
   - Stimulus: in_valid=1 with 4 back-to-back transactions; out_ready=0 for 4 cycles, then 1.
   - Required: in_ready drops after 2 accepts; outputs hold stable while stalled; all 4 results emerge in order, with no loss or duplicate.
5. Reset mid-stream:
   - Stimulus: rst=1 for one cycle with both stages full.
   - Required: the next cycle has out_valid=0 and all outputs 0; the next accepted input emerges after 2 cycles.
6. Optional feature, with COMP_EXP_SPECIAL_EN defined: exp_a=0xFF, exp_b=0x00 -> special_a=1, special_b=0, shift_amt=27, shift_sat=1, exp_max=0xFF.
